// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module : motor_pkg
// Brief  : Shared channel FSM encoding and PWM full-scale helper for the
//          multi-channel motor driver.
// Rev    : 1.0 - initial release
// ============================================================================
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } motor_state_t;

  // Full-scale duty for a signed velocity of vel_w bits.
  function automatic int unsigned motor_maxd(input int unsigned vel_w);
    return (32'd1 << (vel_w - 32'd1)) - 32'd1;
  endfunction

  localparam int unsigned C_DEFAULT_VEL_W = 8;
  localparam int unsigned C_DEFAULT_MAXD  = (1 << (C_DEFAULT_VEL_W - 1)) - 1;

endpackage
`default_nettype wire

// File: rtl/motor_channel.sv
`default_nettype none
// ============================================================================
// Module : motor_channel
// Brief  : One H-bridge channel: velocity magnitude/sign, IDLE/RUN/DEAD FSM,
//          duty register with optional slew (SLEW_LIMIT_EN), ena/dir flops.
// Rev    : 1.0 - initial release
// ============================================================================
module motor_channel
  import motor_pkg::*;
#(
  parameter int VEL_W     = 8,
  parameter int DEADTIME  = 2,
  parameter int SLEW_STEP = 8
) (
  input  logic             cclk,
  input  logic             rst,
  input  logic             boundary,
  input  logic             enable,
  input  logic [VEL_W-1:0] velocity,
  input  logic [VEL_W-2:0] pwm_cnt,
  output logic             ena,
  output logic             dir
);

  localparam int                C_PW      = VEL_W - 1;
  localparam int unsigned       C_MAXD_I  = motor_maxd(VEL_W);
  localparam logic [C_PW-1:0]   C_MAXD    = C_PW'(C_MAXD_I);
  localparam int                C_DT_W    = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [C_DT_W-1:0] C_DT_LOAD = C_DT_W'(DEADTIME - 1);
`ifdef SLEW_LIMIT_EN
  localparam int unsigned       C_STEP    = SLEW_STEP;
`else
  // A step of at least MAXD reaches any target within one period.
  localparam int unsigned       C_STEP    = (SLEW_STEP > C_MAXD_I) ? SLEW_STEP : C_MAXD_I;
`endif

  motor_state_t      r_state, w_state_nxt;
  logic [C_PW-1:0]   r_duty, w_duty_nxt, w_duty_step;
  logic [C_DT_W-1:0] r_dt, w_dt_nxt;
  logic              r_dir, w_dir_nxt;
  logic              r_ena;
  logic              w_neg, w_req, w_rev;
  logic [VEL_W-1:0]  w_negv;
  logic [C_PW-1:0]   w_mag;

  function automatic logic [C_PW-1:0] f_move(input logic [C_PW-1:0] cur,
                                             input logic [C_PW-1:0] tgt);
    logic [31:0] c, t;
    c = 32'(cur);
    t = 32'(tgt);
    if (t > c) f_move = (t - c > C_STEP) ? C_PW'(c + C_STEP) : tgt;
    else       f_move = (c - t > C_STEP) ? C_PW'(c - C_STEP) : tgt;
  endfunction

  // The most-negative code has no positive twin; it saturates to full scale.
  assign w_neg  = velocity[VEL_W-1];
  assign w_negv = -velocity;
  assign w_mag  = !w_neg ? velocity[C_PW-1:0]
                         : (w_negv[VEL_W-1] ? C_MAXD : w_negv[C_PW-1:0]);
  assign w_req  = enable && (w_mag != '0);
  assign w_rev  = w_req && (w_neg != r_dir);

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir;
    w_dt_nxt    = r_dt;
    w_duty_step = f_move(r_duty, (w_req && !w_rev) ? w_mag : '0);
    if (boundary) begin
      unique case (r_state)
        ST_IDLE: begin
          w_duty_nxt = '0;
          if (w_rev) begin
            w_state_nxt = ST_DEAD;
            w_dir_nxt   = w_neg;
            w_dt_nxt    = C_DT_LOAD;
          end else if (w_req) begin
            w_state_nxt = ST_RUN;
            w_duty_nxt  = w_duty_step;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = '0;
          end else begin
            w_duty_nxt = w_duty_step;
            // Leave RUN only once the applied duty has reached zero.
            if (w_duty_step == '0) begin
              if (w_rev) begin
                w_state_nxt = ST_DEAD;
                w_dir_nxt   = w_neg;
                w_dt_nxt    = C_DT_LOAD;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          end
        end
        ST_DEAD: begin
          w_duty_nxt = '0;
          if (w_rev) begin
            w_dir_nxt = w_neg;
            w_dt_nxt  = C_DT_LOAD;
          end else if (r_dt == '0) begin
            if (w_req) begin
              w_state_nxt = ST_RUN;
              w_duty_nxt  = w_duty_step;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_dt_nxt = r_dt - C_DT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_dt    <= '0;
      r_dir   <= 1'b0;
      r_ena   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_dt    <= w_dt_nxt;
      r_dir   <= w_dir_nxt;
      r_ena   <= (w_state_nxt == ST_RUN) && (pwm_cnt < w_duty_nxt);
    end
  end

  assign ena = r_ena;
  assign dir = r_dir;

endmodule
`default_nettype wire

// File: rtl/multi_motor_driver.sv
`default_nettype none
// ============================================================================
// Module : multi_motor_driver
// Brief  : N-channel signed-velocity PWM H-bridge driver with a shared PWM
//          timebase. Optional duty slew limiting via SLEW_LIMIT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module multi_motor_driver
  import motor_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int VEL_W     = 8,
  parameter int PRESCALE  = 1,
  parameter int DEADTIME  = 2,
  parameter int SLEW_STEP = 8
) (
  input  logic                  cclk,
  input  logic                  rst,
  input  logic [N_CH*VEL_W-1:0] velocity,
  input  logic                  enable,
  output logic [N_CH-1:0]       ena,
  output logic [N_CH-1:0]       dir,
  output logic                  period_start
);

  localparam int                C_PW       = VEL_W - 1;
  localparam logic [C_PW-1:0]   C_CNT_LAST = C_PW'(motor_maxd(VEL_W) - 1);
  localparam int                C_PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [C_PS_W-1:0] C_PS_LAST  = C_PS_W'(PRESCALE - 1);

  logic [C_PS_W-1:0] r_prescaler;
  logic [C_PW-1:0]   r_pwm_cnt;
  logic              r_period_start;
  logic              w_boundary;

  assign w_boundary = (r_prescaler == '0) && (r_pwm_cnt == '0);

  always_ff @(posedge cclk) begin
    if (rst) begin
      r_prescaler    <= '0;
      r_pwm_cnt      <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
      if (r_prescaler == C_PS_LAST) begin
        r_prescaler <= '0;
        r_pwm_cnt   <= (r_pwm_cnt == C_CNT_LAST) ? '0 : r_pwm_cnt + 1'b1;
      end else begin
        r_prescaler <= r_prescaler + 1'b1;
      end
    end
  end

  assign period_start = r_period_start;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    motor_channel #(
      .VEL_W    (VEL_W),
      .DEADTIME (DEADTIME),
      .SLEW_STEP(SLEW_STEP)
    ) u_ch (
      .cclk    (cclk),
      .rst     (rst),
      .boundary(w_boundary),
      .enable  (enable),
      .velocity(velocity[g*VEL_W +: VEL_W]),
      .pwm_cnt (r_pwm_cnt),
      .ena     (ena[g]),
      .dir     (dir[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_motor_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_multi_motor_driver
// Brief  : Self-checking bench for multi_motor_driver (N_CH=2, VEL_W=8,
//          PRESCALE=1, DEADTIME=2); period-level model plus directed checks.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_multi_motor_driver;

  localparam int N_CH      = 2;
  localparam int VEL_W     = 8;
  localparam int PRESCALE  = 1;
  localparam int DEADTIME  = 2;
  localparam int SLEW_STEP = 8;
  localparam int MAXD      = 127;

  logic                  cclk = 1'b0;
  logic                  rst = 1'b1;
  logic                  enable = 1'b1;
  logic [N_CH*VEL_W-1:0] velocity = '0;
  logic [N_CH-1:0]       ena, dir;
  logic                  period_start;

  multi_motor_driver #(
    .N_CH(N_CH), .VEL_W(VEL_W), .PRESCALE(PRESCALE),
    .DEADTIME(DEADTIME), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .cclk(cclk), .rst(rst), .velocity(velocity), .enable(enable),
    .ena(ena), .dir(dir), .period_start(period_start)
  );

  always #5 cclk = ~cclk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- period-level model ----------------
  int          m_pos;
  int          m_duty [N_CH];
  int          m_dead [N_CH];
  logic        m_dir  [N_CH];
  logic [N_CH-1:0] exp_ena, exp_dir;
  logic        exp_ps;
  bit          chk_on = 0;

  function automatic int f_mag(input logic [7:0] v);
    int s;
    s = $signed(v);
    if (s < 0) s = -s;
    if (s > MAXD) s = MAXD;
    return s;
  endfunction

  function automatic int step_toward(input int cur, input int tgt);
`ifdef SLEW_LIMIT_EN
    if (tgt > cur) return (tgt - cur > SLEW_STEP) ? cur + SLEW_STEP : tgt;
    else           return (cur - tgt > SLEW_STEP) ? cur - SLEW_STEP : tgt;
`else
    return (cur >= 0) ? tgt : tgt;
`endif
  endfunction

  task automatic model_boundary(input int ch, input logic [7:0] v, input logic en);
    int   m;
    logic s, want;
    m    = f_mag(v);
    s    = v[7];
    want = en && (m > 0);
    if (m_dead[ch] > 0) begin
      if (want && s != m_dir[ch]) begin
        m_dir[ch]  = s;
        m_dead[ch] = DEADTIME;
      end else begin
        m_dead[ch]--;
        if (m_dead[ch] == 0) m_duty[ch] = want ? step_toward(0, m) : 0;
      end
    end else if (!en) begin
      m_duty[ch] = 0;
    end else begin
      m_duty[ch] = step_toward(m_duty[ch], (want && s == m_dir[ch]) ? m : 0);
      if (m_duty[ch] == 0 && want && s != m_dir[ch]) begin
        m_dir[ch]  = s;
        m_dead[ch] = DEADTIME;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge cclk);
      if (rst) begin
        m_pos = 0;
        for (int c = 0; c < N_CH; c++) begin
          m_duty[c] = 0;
          m_dead[c] = 0;
          m_dir[c]  = 1'b0;
        end
        exp_ena = '0;
        exp_dir = '0;
        exp_ps  = 1'b0;
        chk_on  = 1;
      end else begin
        if (m_pos == 0)
          for (int c = 0; c < N_CH; c++) model_boundary(c, velocity[c*VEL_W +: VEL_W], enable);
        exp_ps = (m_pos == 0);
        for (int c = 0; c < N_CH; c++) begin
          exp_ena[c] = (m_dead[c] == 0) && (m_pos < m_duty[c]);
          exp_dir[c] = m_dir[c];
        end
        m_pos = (m_pos + 1) % MAXD;
      end
      @(negedge cclk);
      if (chk_on) begin
        chk("ena", 32'(ena), 32'(exp_ena));
        chk("dir", 32'(dir), 32'(exp_dir));
        chk("period_start", 32'(period_start), 32'(exp_ps));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_vel(input logic [7:0] v0, input logic [7:0] v1);
    repeat (5) @(negedge cclk);
    velocity = {v1, v0};
  endtask

  task automatic measure(output int h0, output int h1, output logic [1:0] d);
    int guard;
    guard = 0;
    h0 = 0;
    h1 = 0;
    while (period_start !== 1'b1 && guard < 400) begin
      @(negedge cclk);
      guard++;
    end
    if (guard >= 400) begin
      total++;
      bad++;
      $display("FAIL ps_wait_timeout: got no period_start within %0d cycles", guard);
    end
    d = dir;
    for (int k = 0; k < MAXD; k++) begin
      h0 += int'(ena[0]);
      h1 += int'(ena[1]);
      @(negedge cclk);
    end
  endtask

  task automatic expect_period(input string name, input int e0, input int e1, input logic [1:0] ed);
    int h0, h1;
    logic [1:0] d;
    measure(h0, h1, d);
    chk({name, "_ch0_high"}, 32'(h0), 32'(e0));
    chk({name, "_ch1_high"}, 32'(h1), 32'(e1));
    chk({name, "_dir"}, 32'(d), 32'(ed));
  endtask

  initial begin
    int n, h1;
    repeat (3) @(negedge cclk);
    chk("rst_ena", 32'(ena), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    rst = 1'b0;
    @(negedge cclk);
    chk("ps_after_release", 32'(period_start), 32'd1);
    n = 0;
    do begin
      @(negedge cclk);
      n++;
    end while (period_start !== 1'b1 && n < 400);
    chk("ps_interval", 32'(n), 32'd127);

`ifndef SLEW_LIMIT_EN
    set_vel(8'h42, 8'h00);
    expect_period("v42", 66, 0, 2'b00);
    set_vel(8'h7f, 8'h00);
    expect_period("v7f", 127, 0, 2'b00);
    set_vel(8'h80, 8'h00);
    expect_period("v80_dead1", 0, 0, 2'b01);
    expect_period("v80_dead2", 0, 0, 2'b01);
    expect_period("v80_run", 127, 0, 2'b01);
    set_vel(8'h42, 8'h00);
    expect_period("rev42_dead1", 0, 0, 2'b00);
    expect_period("rev42_dead2", 0, 0, 2'b00);
    expect_period("rev42_run", 66, 0, 2'b00);
    set_vel(8'hc6, 8'h00);
    expect_period("vc6_dead1", 0, 0, 2'b01);
    expect_period("vc6_dead2", 0, 0, 2'b01);
    expect_period("vc6_run", 58, 0, 2'b01);

    repeat (40) @(negedge cclk);
    velocity = {8'h20, 8'hc6};
    h1 = 0;
    n = 0;
    while (period_start !== 1'b1 && n < 400) begin
      h1 += int'(ena[1]);
      @(negedge cclk);
      n++;
    end
    chk("mid_change_hold", 32'(h1), 32'd0);
    chk("mid_change_len", 32'(n), 32'd87);
    expect_period("mid_change_next", 58, 32, 2'b01);

    repeat (5) @(negedge cclk);
    enable = 1'b0;
    expect_period("disabled", 0, 0, 2'b01);
    repeat (5) @(negedge cclk);
    enable = 1'b1;
    expect_period("reenabled", 58, 32, 2'b01);

    repeat (60) @(negedge cclk);
    chk("pre_rst_dir", 32'(dir), 32'd1);
    rst = 1'b1;
    @(negedge cclk);
    chk("mid_rst_ena", 32'(ena), 32'd0);
    chk("mid_rst_dir", 32'(dir), 32'd0);
    chk("mid_rst_ps", 32'(period_start), 32'd0);
    rst = 1'b0;
    expect_period("post_rst_dead1", 0, 32, 2'b01);
    expect_period("post_rst_dead2", 0, 32, 2'b01);
    expect_period("post_rst_run", 58, 32, 2'b01);
`else
    set_vel(8'h7f, 8'h00);
    for (int k = 1; k <= 16; k++)
      expect_period("slew_up", (k * 8 > 127) ? 127 : k * 8, 0, 2'b00);
    set_vel(8'h81, 8'h00);
    for (int k = 1; k <= 15; k++)
      expect_period("slew_down", 127 - k * 8, 0, 2'b00);
    expect_period("slew_dead1", 0, 0, 2'b01);
    expect_period("slew_dead2", 0, 0, 2'b01);
    for (int k = 1; k <= 3; k++)
      expect_period("slew_rev_up", k * 8, 0, 2'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
